// File: rtl/muldiv_sequencer.sv
// Iterative multiply/divide engine: shift-add multiply, restoring divide, one bit per cycle,
// followed by a single sign-correction cycle. Stalls the PC while the operation is in flight.
module muldiv_sequencer #(
    parameter  int W  = 16,
    localparam int CW = $clog2(W) + 1
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         stall,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] hi,
    output logic [W-1:0] lo,
    output logic         dbz
);

    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   count_reg;
    logic [1:0]      op_reg;
    logic [W-1:0]    a_reg;
    logic [W-1:0]    opnd_reg;
    logic [2*W-1:0]  acc_reg;
    logic            sign_a_reg, sign_b_reg, bz_reg;
    logic [W-1:0]    hi_reg, lo_reg;
    logic            dbz_reg;

    logic [W-1:0]    mag_a, mag_b;
    logic [W:0]      mul_sum;
    logic [2*W-1:0]  mul_step;
    logic [W:0]      div_shift, div_diff;
    logic [2*W-1:0]  div_step;
    logic [2*W-1:0]  prod_fix;
    logic [W-1:0]    quot_fix, rem_fix;

    // Signed ops work on magnitudes; -2^(W-1) maps onto itself, which is its correct unsigned magnitude.
    assign mag_a = (op[0] && a[W-1]) ? (~a + 1'b1) : a;
    assign mag_b = (op[0] && b[W-1]) ? (~b + 1'b1) : b;

    // Multiply: multiplier sits in acc low half and is shifted out as the product shifts in.
    assign mul_sum  = {1'b0, acc_reg[2*W-1:W]} + (acc_reg[0] ? {1'b0, opnd_reg} : {(W+1){1'b0}});
    assign mul_step = {mul_sum, acc_reg[W-1:1]};

    // Divide: acc holds {remainder, dividend/quotient}; bit W of the difference flags a negative trial.
    assign div_shift = {acc_reg[2*W-1:W], acc_reg[W-1]};
    assign div_diff  = div_shift - {1'b0, opnd_reg};
    assign div_step  = div_diff[W] ? {div_shift[W-1:0], acc_reg[W-2:0], 1'b0}
                                   : {div_diff[W-1:0],  acc_reg[W-2:0], 1'b1};

    assign prod_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg + 1'b1) : acc_reg;
    assign quot_fix = (sign_a_reg ^ sign_b_reg) ? (~acc_reg[W-1:0] + 1'b1) : acc_reg[W-1:0];
    assign rem_fix  = sign_a_reg ? (~acc_reg[2*W-1:W] + 1'b1) : acc_reg[2*W-1:W];

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = IDLE;
        case (state_reg)
            IDLE: state_next = start ? RUN : IDLE;
            RUN: begin
                if (count_reg == CW'(W-1))     state_next = FIX;
                else if (count_reg > CW'(W-1)) state_next = IDLE;
                else                           state_next = RUN;
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        stall = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state_reg)
            IDLE:    stall = start;
            RUN,
            FIX:     begin stall = 1'b1; busy = 1'b1; end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            count_reg  <= '0;
            op_reg     <= '0;
            a_reg      <= '0;
            opnd_reg   <= '0;
            acc_reg    <= '0;
            sign_a_reg <= 1'b0;
            sign_b_reg <= 1'b0;
            bz_reg     <= 1'b0;
            hi_reg     <= '0;
            lo_reg     <= '0;
            dbz_reg    <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    count_reg <= '0;
                    if (start) begin
                        op_reg     <= op;
                        a_reg      <= a;
                        sign_a_reg <= op[0] & a[W-1];
                        sign_b_reg <= op[0] & b[W-1];
                        bz_reg     <= (b == '0);
                        opnd_reg   <= op[1] ? mag_b : mag_a;
                        acc_reg    <= {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
                    end
                end
                RUN: begin
                    acc_reg   <= op_reg[1] ? div_step : mul_step;
                    count_reg <= count_reg + CW'(1);
                end
                FIX: begin
                    if (!op_reg[1]) begin
                        hi_reg  <= prod_fix[2*W-1:W];
                        lo_reg  <= prod_fix[W-1:0];
                        dbz_reg <= 1'b0;
                    end else if (bz_reg) begin
                        hi_reg  <= a_reg;
                        lo_reg  <= '1;
                        dbz_reg <= 1'b1;
                    end else begin
                        hi_reg  <= rem_fix;
                        lo_reg  <= quot_fix;
                        dbz_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign hi  = hi_reg;
    assign lo  = lo_reg;
    assign dbz = dbz_reg;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed + random bench for muldiv_sequencer; expected results queued at issue, popped at done.
module tb_muldiv_sequencer;

    localparam int W = 16;

    logic         Clk = 1'b0;
    logic         Reset = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = '0;
    logic [W-1:0] a = '0, b = '0;
    logic         stall, busy, done, dbz;
    logic [W-1:0] hi, lo;

    muldiv_sequencer #(.W(W)) dut (
        .Clk(Clk), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
        .stall(stall), .busy(busy), .done(done), .hi(hi), .lo(lo), .dbz(dbz)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
    } exp_t;

    exp_t exp_q[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;
    int   done_cnt = 0;

    always @(negedge Clk) if (done === 1'b1) done_cnt++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total_cnt++;
        assert (obs === expv) pass_cnt++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    endtask

    // Reference model from plain integer arithmetic.
    function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
        exp_t e;
        logic [31:0] p;
        int sx, sy, q, r;
        sx = int'($signed(x));
        sy = int'($signed(y));
        e.dbz = 1'b0;
        case (o)
            2'b00: begin p = {16'h0, x} * {16'h0, y}; e.hi = p[31:16]; e.lo = p[15:0]; end
            2'b01: begin p = 32'(sx * sy); e.hi = p[31:16]; e.lo = p[15:0]; end
            default: begin
                if (y == '0) begin
                    e.hi = x; e.lo = '1; e.dbz = 1'b1;
                end else if (o == 2'b10) begin
                    e.lo = x / y; e.hi = x % y;
                end else begin
                    q = sx / sy; r = sx % sy;
                    e.lo = q[15:0]; e.hi = r[15:0];
                end
            end
        endcase
        return e;
    endfunction

    // Issue one op, scramble inputs after acceptance, optionally poke start in RUN cycle 3 / DONE.
    task automatic run_op(input string tag, input logic [1:0] o, input logic [W-1:0] x,
                          input logic [W-1:0] y, input exp_t e, input bit poke);
        int m, stall_cnt, d0;
        exp_t got;
        exp_t want;
        exp_q.push_back(e);
        @(negedge Clk);
        op = o; a = x; b = y; start = 1'b1;
        #1 chk({tag, ".stall_req"}, 32'(stall), 32'd1);
        @(negedge Clk);
        start = 1'b0;
        op = 2'($urandom); a = W'($urandom); b = W'($urandom);
        d0 = done_cnt;
        m = 0; stall_cnt = 0;
        while (done !== 1'b1 && m < 40) begin
            if (stall === 1'b1) stall_cnt++;
            start = (poke && m == 3);
            @(negedge Clk);
            m++;
        end
        start = 1'b0;
        chk({tag, ".latency"}, 32'(m), 32'(W + 1));
        chk({tag, ".stall_cycles"}, 32'(stall_cnt), 32'(W + 1));
        chk({tag, ".stall_at_done"}, 32'(stall), 32'd0);
        want = exp_q.pop_front();
        got = '{hi: hi, lo: lo, dbz: dbz};
        $display("op=%b a=%h b=%h -> hi=%h lo=%h dbz=%b (exp %h %h %b) [%s]",
                 o, x, y, hi, lo, dbz, want.hi, want.lo, want.dbz, tag);
        chk({tag, ".hi"}, 32'(got.hi), 32'(want.hi));
        chk({tag, ".lo"}, 32'(got.lo), 32'(want.lo));
        chk({tag, ".dbz"}, 32'(got.dbz), 32'(want.dbz));
        if (poke) start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        chk({tag, ".done_pulse"}, 32'(done), 32'd0);
        if (poke) begin
            repeat (4) @(negedge Clk);
            #1;
            chk({tag, ".one_done"}, 32'(done_cnt - d0), 32'd1);
            chk({tag, ".idle_busy"}, 32'(busy), 32'd0);
            chk({tag, ".hold_hi"}, 32'(hi), 32'(want.hi));
            chk({tag, ".hold_lo"}, 32'(lo), 32'(want.lo));
        end
    endtask

    initial begin
        int d0;
        logic [1:0] ro;
        logic [W-1:0] ra, rb;

        #1;
        chk("rst.hi", 32'(hi), 32'd0);
        chk("rst.lo", 32'(lo), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.done", 32'(done), 32'd0);
        chk("rst.dbz", 32'(dbz), 32'd0);
        chk("rst.stall", 32'(stall), 32'd0);
        start = 1'b1;
        #1 chk("rst.stall_start", 32'(stall), 32'd1);
        start = 1'b0;
        @(negedge Clk); @(negedge Clk);
        Reset = 1'b0;

        run_op("mulu_3x5",   2'b00, 16'h0003, 16'h0005, '{16'h0000, 16'h000F, 1'b0}, 0);
        run_op("muls_m3x5",  2'b01, 16'hFFFD, 16'h0005, '{16'hFFFF, 16'hFFF1, 1'b0}, 0);
        run_op("muls_min2",  2'b01, 16'h8000, 16'h8000, '{16'h4000, 16'h0000, 1'b0}, 0);
        run_op("divu_100_7", 2'b10, 16'h0064, 16'h0007, '{16'h0002, 16'h000E, 1'b0}, 0);
        run_op("divs_m7_2",  2'b11, 16'hFFF9, 16'h0002, '{16'hFFFF, 16'hFFFD, 1'b0}, 0);
        run_op("divu_dbz",   2'b10, 16'h1234, 16'h0000, '{16'h1234, 16'hFFFF, 1'b1}, 0);
        run_op("divs_ovf",   2'b11, 16'h8000, 16'hFFFF, '{16'h0000, 16'h8000, 1'b0}, 0);
        run_op("divs_dbz",   2'b11, 16'hFF00, 16'h0000, '{16'hFF00, 16'hFFFF, 1'b1}, 0);
        run_op("mulu_max",   2'b00, 16'hFFFF, 16'hFFFF, model(2'b00, 16'hFFFF, 16'hFFFF), 0);
        run_op("poke",       2'b10, 16'h0BAD, 16'h0013, model(2'b10, 16'h0BAD, 16'h0013), 1);

        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom); ra = W'($urandom); rb = W'($urandom);
            if (i == 3) rb = '0;
            run_op($sformatf("rand%0d", i), ro, ra, rb, model(ro, ra, rb), 0);
        end

        // Abort in RUN cycle 5: everything drops at once and no done follows.
        @(negedge Clk);
        op = 2'b00; a = 16'h0101; b = 16'h0202; start = 1'b1;
        @(negedge Clk);
        start = 1'b0;
        d0 = done_cnt;
        repeat (5) @(negedge Clk);
        Reset = 1'b1;
        #1;
        chk("abort.busy", 32'(busy), 32'd0);
        chk("abort.stall", 32'(stall), 32'd0);
        chk("abort.hi", 32'(hi), 32'd0);
        chk("abort.lo", 32'(lo), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (W + 4) @(negedge Clk);
        #1 chk("abort.no_done", 32'(done_cnt - d0), 32'd0);
        $display("reset mid-run: done_cnt delta=%0d", done_cnt - d0);
        run_op("post_abort", 2'b01, 16'h0007, 16'hFFFA, model(2'b01, 16'h0007, 16'hFFFA), 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
